// File: rtl/d0_drain_pkg.sv
// d0_drain_pkg: shared FSM encodings and skid depth for the D0 drain controller.
package d0_drain_pkg;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_STALL  = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;
    localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/d0_drain_ctrl_skid.sv
// skid_buf2: 2-entry fall-through buffer; an empty buffer passes din straight to dout.
module skid_buf2 #(
    parameter int BW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [BW-1:0] din,
    input  logic          rd,
    output logic [BW-1:0] dout,
    output logic [1:0]    occ,
    output logic          overflow
);
    logic [BW-1:0] r_mem [2];
    logic          r_head;
    logic [1:0]    r_occ;
    logic          w_store, w_pop, w_tail;
    // a word read in the same cycle it arrives into an empty buffer is never stored
    assign w_store  = wr & (r_occ != 2'd0 | !rd) & !(r_occ == 2'd2 & !rd);
    assign w_pop    = rd & (r_occ != 2'd0);
    assign w_tail   = r_head ^ r_occ[0];
    assign overflow = wr & (r_occ == 2'd2) & !rd;
    assign dout     = (r_occ == 2'd0) ? din : r_mem[r_head];
    assign occ      = r_occ;
    always_ff @(posedge clk) begin
        if (w_store) r_mem[w_tail] <= din;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= 1'b0;
            r_occ  <= 2'd0;
        end else begin
            if (w_pop) r_head <= ~r_head;
            r_occ <= r_occ + {1'b0, w_store} - {1'b0, w_pop};
        end
    end
endmodule

// File: rtl/d0_drain_ctrl.sv
// d0_drain_ctrl: pops the D0 FIFO under a credit rule and presents words on a valid/ready port.
module d0_drain_ctrl
    import d0_drain_pkg::*;
#(
    parameter int BW     = 6,
    parameter int CW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          D0_empty,
    input  logic          D0_almost_empty,
    input  logic          D0_error_output,
    input  logic [BW-1:0] D0_data_out,
    output logic          D0_rd,
    output logic [BW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] drained_count,
    output logic          busy,
    output logic          error
);
    generate
        if (RD_LAT != 1) begin : g_bad_rd_lat
            $error("d0_drain_ctrl supports RD_LAT=1 only");
        end
    endgenerate
    logic [1:0]    r_state, w_next, w_occ;
    logic          r_inflight, w_pop, w_ovf, w_go, w_pend, w_full, w_unused;
    logic [BW-1:0] w_dout;
    assign w_unused  = D0_almost_empty;
    assign out_valid = (w_occ != 2'd0) | r_inflight;
    assign w_pop     = out_valid & out_ready;
    assign out_data  = out_valid ? w_dout : '0;
    assign busy      = r_state != ST_IDLE;
    assign w_go      = enable & !D0_empty;
    assign w_pend    = r_inflight | (w_occ != 2'd0);
    assign w_full    = w_occ == 2'(SKID_DEPTH);
    // a word popped downstream this cycle frees one credit for a new read
    assign D0_rd = !reset & w_go &
                   (({1'b0, w_occ} + {2'b0, r_inflight}) < (3'(SKID_DEPTH) + {2'b0, w_pop}));
    assign w_next = (r_state == ST_IDLE)   ? (w_go ? ST_ACTIVE : ST_IDLE) :
                    (r_state == ST_ACTIVE) ? ((w_full & !out_ready) ? ST_STALL :
                                              !w_go ? (w_pend ? ST_DRAIN : ST_IDLE) : ST_ACTIVE) :
                    (r_state == ST_STALL)  ? (out_ready ? ST_ACTIVE : ST_STALL) :
                    w_go ? ST_ACTIVE : w_pend ? ST_DRAIN : ST_IDLE;
    skid_buf2 #(.BW(BW)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .wr       (r_inflight),
        .din      (D0_data_out),
        .rd       (out_ready),
        .dout     (w_dout),
        .occ      (w_occ),
        .overflow (w_ovf)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_inflight    <= 1'b0;
            drained_count <= '0;
            error         <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inflight <= D0_rd;
            if (w_pop) drained_count <= drained_count + 1'b1;
            if (D0_error_output | (D0_rd & D0_empty) | w_ovf) error <= 1'b1;
        end
    end
endmodule
